// File: rtl/mips_cpu_hilo_pkg.sv
// Shared op-codes, FSM state type and helpers for the HI/LO multiply/divide unit.
// The op-code values are also used by the control decoder.
package mips_cpu_hilo_pkg;

  localparam logic [4:0] OpMult  = 5'd2;
  localparam logic [4:0] OpMultu = 5'd22;
  localparam logic [4:0] OpDiv   = 5'd3;
  localparam logic [4:0] OpDivu  = 5'd23;
  localparam logic [4:0] OpMthi  = 5'd24;
  localparam logic [4:0] OpMtlo  = 5'd25;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } state_e;

  // Unsigned magnitude: abs(0x80000000) stays 0x80000000.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/mips_cpu_divstep.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference and emit a 1 quotient bit when it does not borrow.
module mips_cpu_divstep (
  input  logic [32:0] rem,
  input  logic        dbit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic        qbit
);

  logic [33:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted  = {rem, dbit};
    diff     = shifted - {2'b00, divisor};
    qbit     = ~diff[33];
    rem_next = qbit ? diff[32:0] : shifted[32:0];
  end

endmodule

// File: rtl/mips_cpu_hilo_muldiv.sv
// Iterative multiply/divide unit owning HI/LO; also applies MTHI/MTLO writes.
// Define MIPS_CPU_MULDIV_FAST_MUL_EN for a single-cycle multiply (divide is unchanged).
module mips_cpu_hilo_muldiv
  import mips_cpu_hilo_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                is_div_q, is_div_d;
  logic                done_q, done_d;

  logic                is_signed;
  logic [XLEN-1:0]     a_abs, b_abs;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN:0]       rem_next;
  logic                qbit;

  // The remainder register only ever holds values below the divisor.
  mips_cpu_divstep u_divstep (
    .rem      (rem_q),
    .dbit     (acc_q[XLEN-1]),
    .divisor  (opnd_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_comb begin
    is_signed = (op == OpMult) || (op == OpDiv);
    a_abs     = is_signed ? abs32(a) : a;
    b_abs     = is_signed ? abs32(b) : b;
    // acc holds {partial product, remaining multiplier bits}.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    prod_fix  = neg_quo_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu: begin
              neg_quo_d = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
              neg_rem_d = is_signed & a[XLEN-1];
              is_div_d  = 1'b0;
              cnt_d     = '0;
              opnd_d    = a_abs;
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
              acc_d     = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
              state_d   = StFix;
`else
              acc_d     = {{XLEN{1'b0}}, b_abs};
              state_d   = StMul;
`endif
            end
            OpDiv, OpDivu: begin
              neg_quo_d = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
              neg_rem_d = is_signed & a[XLEN-1];
              is_div_d  = 1'b1;
              cnt_d     = '0;
              opnd_d    = b_abs;
              acc_d     = {{XLEN{1'b0}}, a_abs};
              rem_d     = '0;
              state_d   = StDiv;
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = StFix;
      end
      StDiv: begin
        // Low half shifts dividend bits out the top and quotient bits in the bottom.
        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], qbit};
        rem_d = rem_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          hi_d = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Self-checking bench for the HI/LO multiply/divide unit: directed plan vectors plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_mips_cpu_hilo_muldiv;

  localparam logic [4:0] OP_MULT  = 5'd2;
  localparam logic [4:0] OP_MULTU = 5'd22;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd23;
  localparam logic [4:0] OP_MTHI  = 5'd24;
  localparam logic [4:0] OP_MTLO  = 5'd25;
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op = 5'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_cpu_hilo_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference model straight from the architectural rules.
  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = 32'd0;
    l = 32'd0;
    case (o)
      OP_MULT: begin
        q = sx * sy;
        p = q;
        h = p[63:32];
        l = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, x} * {32'd0, y};
        h = p[63:32];
        l = p[31:0];
      end
      OP_DIV: begin
        if (y == 32'd0) begin
          l = x[31] ? 32'd1 : 32'hFFFF_FFFF;
          h = x;
        end else begin
          q = sx / sy;
          r = sx % sy;
          l = q[31:0];
          h = r[31:0];
        end
      end
      OP_DIVU: begin
        if (y == 32'd0) begin
          l = 32'hFFFF_FFFF;
          h = x;
        end else begin
          l = x / y;
          h = x % y;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 5'd0;
  endtask

  // Counts edges after the start edge until done; -1 when the bound expires.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tests_run++;
    if (hi !== 32'd0) begin fails++; $display("FAIL reset_hi got=%h want=0", hi); end
    tests_run++;
    if (lo !== 32'd0) begin fails++; $display("FAIL reset_lo got=%h want=0", lo); end
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    tests_run++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", done); end
  endtask

  task automatic test_mthi_mtlo();
    logic saw_busy;
    saw_busy = 1'b0;
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    saw_busy |= (busy !== 1'b0) | (done !== 1'b0);
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    saw_busy |= (busy !== 1'b0) | (done !== 1'b0);
    @(posedge clk);
    #1;
    saw_busy |= (busy !== 1'b0) | (done !== 1'b0);
    tests_run++;
    if (hi !== 32'h1234_5678) begin fails++; $display("FAIL mthi got=%h want=12345678", hi); end
    tests_run++;
    if (lo !== 32'h9ABC_DEF0) begin fails++; $display("FAIL mtlo got=%h want=9abcdef0", lo); end
    tests_run++;
    if (saw_busy) begin fails++; $display("FAIL mt_no_busy got=busy/done high want=low"); end
  endtask

  task automatic test_reset_mid();
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got=%b want=0", busy); end
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      fails++;
      $display("FAIL midreset_hilo got=%h_%h want=0_0", hi, lo);
    end
    repeat (40) @(posedge clk);
    #1;
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midreset_late got=%h_%h done=%b want=0_0 done=0", hi, lo, done);
    end
  endtask

  task automatic run_and_check(input string name, input logic [4:0] o, input logic [31:0] x,
                               input logic [31:0] y);
    logic [31:0] eh, el;
    int lat, want_lat;
    logic busy_ok;
    model(o, x, y, eh, el);
    want_lat = (o == OP_MULT || o == OP_MULTU) ? MUL_LAT : DIV_LAT;
    issue(o, x, y);
    wait_done(lat, busy_ok);
    tests_run++;
    if (hi !== eh || lo !== el) begin
      fails++;
      $display("FAIL %s op=%0d a=%h b=%h got=%h_%h want=%h_%h", name, o, x, y, hi, lo, eh, el);
    end
    tests_run++;
    if (lat != want_lat || !busy_ok || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_timing got=lat %0d busy_ok %b want=lat %0d", name, lat, busy_ok, want_lat);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin fails++; $display("FAIL %s_pulse got=done %b want=0", name, done); end
  endtask

  task automatic test_directed();
    run_and_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tests_run++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      fails++;
      $display("FAIL multu_const got=%h_%h want=fffffffe_00000001", hi, lo);
    end
    run_and_check("mult_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_and_check("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    tests_run++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      fails++;
      $display("FAIL mult_neg3x7_const got=%h_%h want=ffffffff_ffffffeb", hi, lo);
    end
    run_and_check("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_and_check("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    run_and_check("divu_by0", OP_DIVU, 32'd5, 32'd0);
    run_and_check("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_and_check("div_neg_by0", OP_DIV, 32'hFFFF_FF00, 32'd0);
    run_and_check("mult_zero", OP_MULT, 32'd0, 32'h1234_5678);
  endtask

  task automatic test_random();
    logic [4:0] ops [4];
    ops[0] = OP_MULT;
    ops[1] = OP_MULTU;
    ops[2] = OP_DIV;
    ops[3] = OP_DIVU;
    for (int i = 0; i < 40; i++) begin
      run_and_check("random", ops[$urandom_range(0, 3)], pick_operand(), pick_operand());
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic busy_ok;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    // MTHI while busy must be dropped.
    start = 1'b1;
    op = OP_MTHI;
    a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 5'd0;
    wait_done(lat, busy_ok);
    tests_run++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || lat < 0) begin
      fails++;
      $display("FAIL mthi_busy got=%h_%h lat %0d want=ffffffff_ffffffeb", hi, lo, lat);
    end
    // New start in the cycle done is high.
    start = 1'b1;
    op = OP_DIVU;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 5'd0;
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got=busy %b want=1", busy); end
    wait_done(lat, busy_ok);
    tests_run++;
    if (lo !== 32'd14 || hi !== 32'd2 || lat != DIV_LAT) begin
      fails++;
      $display("FAIL b2b_divu got=%h_%h lat %0d want=00000002_0000000e lat %0d",
               hi, lo, lat, DIV_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_reset_mid();
    test_directed();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
